// File: rtl/lsu_align.sv
// Load/store alignment unit: byte-lane extract for loads, read-modify-write for SB/SH,
// word-only traffic to memory over exec/fin. Optional macro: LSU_MISALIGN_TRAP_EN.
module lsu_align #(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_ready,
    output logic              o_done,
    output logic [31:0]       o_rdata,
    output logic              o_err,
    output logic              o_mem_exec,
    output logic              o_mem_we,
    output logic [2:0]        o_mem_sel,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_data,
    input  logic [31:0]       i_mem_data,
    input  logic              i_mem_fin,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_GAP  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          f3_q;
    logic                we_q;
    logic [1:0]          lane_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic [31:0]         mem_data_q;

    logic                accept;
    logic                f3_ok;
    logic                trap;
    logic [1:0]          lane_d;

    // Handshake: a request is taken only on an edge where i_req=1 and o_ready=1.
    // Memory side: o_mem_exec stays high until i_mem_fin=1 is sampled, and is only
    // raised again after i_mem_fin has been seen low.
    assign accept = i_req && (state_q == S_IDLE);

    always_comb begin
        f3_ok = 1'b0;
        if (i_we) begin
            case (i_funct3)
                3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
                default:                f3_ok = 1'b0;
            endcase
        end else begin
            case (i_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
                default:                                f3_ok = 1'b0;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                  ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // Halves and words are force-aligned; with trapping enabled those cases never reach memory.
    always_comb begin
        case (i_funct3[1:0])
            2'b00:   lane_d = i_addr[1:0];
            2'b01:   lane_d = {i_addr[1], 1'b0};
            default: lane_d = 2'b00;
        endcase
    end

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lane);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (f3)
            3'b000:  load_extract = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_extract = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_extract = {24'h0, sh[7:0]};
            3'b101:  load_extract = {16'h0, sh[15:0]};
            default: load_extract = sh;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wd,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [31:0] mask;
        case (f3[1:0])
            2'b00:   mask = 32'h0000_00FF;
            2'b01:   mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        store_merge = (word & ~(mask << {lane, 3'b000})) | ((wd & mask) << {lane, 3'b000});
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!f3_ok || trap)                      state_d = S_ERR;
                    else if (i_we && (i_funct3 == 3'b010))   state_d = S_WR;
                    else                                     state_d = S_RD;
                end
            end
            S_RD:    if (i_mem_fin) state_d = we_q ? S_GAP : S_DONE;
            S_GAP:   if (!i_mem_fin) state_d = S_WR;
            S_WR:    if (i_mem_fin) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            f3_q       <= 3'b000;
            we_q       <= 1'b0;
            lane_q     <= 2'b00;
            wdata_q    <= 32'h0;
            rdata_q    <= 32'h0;
            mem_data_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q     <= {i_addr[ADDR_W-1:2], 2'b00};
                f3_q       <= i_funct3;
                we_q       <= i_we;
                lane_q     <= lane_d;
                wdata_q    <= i_wdata;
                mem_data_q <= i_wdata;
            end
            if ((state_q == S_RD) && i_mem_fin) begin
                if (we_q) mem_data_q <= store_merge(i_mem_data, wdata_q, f3_q, lane_q);
                else      rdata_q    <= load_extract(i_mem_data, f3_q, lane_q);
            end
        end
    end

    assign o_ready    = (state_q == S_IDLE);
    assign o_done     = (state_q == S_DONE) || (state_q == S_ERR);
    assign o_err      = (state_q == S_ERR);
    assign o_rdata    = rdata_q;
    assign o_mem_exec = (state_q == S_RD) || (state_q == S_WR);
    assign o_mem_we   = (state_q == S_WR);
    assign o_mem_sel  = 3'b010;
    assign o_mem_addr = addr_q;
    assign o_mem_data = mem_data_q;
    assign o_state    = state_q;

endmodule
